// File: rtl/scope_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom frames with flush, idle-timeout and end-of-trace drain.
// Optional refused-atom counter enabled by defining SCOPE_DCT_DROP_COUNT_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RUN   | accepting atoms, emitting full or flushed frames
// ST_DRAIN | end of trace requested; no new atoms, flushing what is held
// ST_ENDED | everything emitted; held until reset
module scope_dct_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        atom_valid,
    input  logic [1:0]  atom,
    output logic        atom_ready,
    input  logic        flush,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        dct_valid,
    input  logic        dct_ready,
    output logic        test_has_ended,
    output logic [15:0] atom_drop_count
);

    localparam int unsigned IW = (FLUSH_TIMEOUT > 0) ? $clog2(FLUSH_TIMEOUT + 1) : 1;
    localparam logic [IW-1:0] IDLE_MAX = IW'(FLUSH_TIMEOUT);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ENDED
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [29:0]    acc;
    logic [3:0]     acc_cnt;
    logic           flush_pend;
    logic           flush_pend_nxt;
    logic [IW-1:0]  idle_cnt;
    logic [IW-1:0]  idle_nxt;
    logic           accept;
    logic           slot_free;
    logic           xfer;
    logic           timeout_hit;

    assign atom_ready     = (state == ST_RUN) && (acc_cnt != 4'd15);
    assign accept         = atom_valid && atom_ready;
    assign slot_free      = !dct_valid || dct_ready;
    assign xfer           = slot_free && ((acc_cnt == 4'd15) || (flush_pend && (acc_cnt != 4'd0)));
    assign test_has_ended = (state == ST_ENDED);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (test_ending) state_nxt = ST_DRAIN;
            ST_DRAIN: if ((acc_cnt == 4'd0) && !dct_valid) state_nxt = ST_ENDED;
            ST_ENDED: state_nxt = ST_ENDED;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // The timeout fires on the edge where the idle counter reaches its limit,
    // so the frame appears one cycle later.
    always_comb begin
        idle_nxt = idle_cnt;
        if (accept || (acc_cnt == 4'd0)) begin
            idle_nxt = '0;
        end else if (idle_cnt != IDLE_MAX) begin
            idle_nxt = idle_cnt + 1'b1;
        end
    end

    assign timeout_hit = (FLUSH_TIMEOUT != 0) && (acc_cnt != 4'd0) && (idle_nxt == IDLE_MAX);

    always_comb begin
        flush_pend_nxt = flush_pend | flush | timeout_hit | (state == ST_DRAIN);
        if (xfer || (acc_cnt == 4'd0)) begin
            flush_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc        <= '0;
            acc_cnt    <= '0;
            flush_pend <= 1'b0;
            idle_cnt   <= '0;
            dct_buffer <= '0;
            dct_count  <= '0;
            dct_valid  <= 1'b0;
        end else begin
            flush_pend <= flush_pend_nxt;
            idle_cnt   <= idle_nxt;
            if (xfer) begin
                dct_buffer <= acc;
                dct_count  <= acc_cnt;
                dct_valid  <= 1'b1;
                // An atom accepted alongside a flush starts the next frame.
                if (accept) begin
                    acc     <= {28'd0, atom};
                    acc_cnt <= 4'd1;
                end else begin
                    acc     <= '0;
                    acc_cnt <= '0;
                end
            end else begin
                if (dct_ready) begin
                    dct_valid <= 1'b0;
                end
                if (accept) begin
                    acc[{acc_cnt, 1'b0} +: 2] <= atom;
                    acc_cnt                   <= acc_cnt + 4'd1;
                end
            end
        end
    end

`ifdef SCOPE_DCT_DROP_COUNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt <= '0;
        end else if ((state == ST_RUN) && atom_valid && !atom_ready && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign atom_drop_count = drop_cnt;
`else
    assign atom_drop_count = '0;
`endif

endmodule

// File: tb/tb_scope_dct_packer.sv
// Directed bench for scope_dct_packer with FLUSH_TIMEOUT=4.
module tb_scope_dct_packer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        atom_valid;
    logic [1:0]  atom;
    logic        atom_ready;
    logic        flush;
    logic        test_ending;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        dct_valid;
    logic        dct_ready;
    logic        test_has_ended;
    logic [15:0] atom_drop_count;

    int n_checks = 0;
    int n_errors = 0;

    scope_dct_packer #(.FLUSH_TIMEOUT(4)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .atom_valid      (atom_valid),
        .atom            (atom),
        .atom_ready      (atom_ready),
        .flush           (flush),
        .test_ending     (test_ending),
        .dct_buffer      (dct_buffer),
        .dct_count       (dct_count),
        .dct_valid       (dct_valid),
        .dct_ready       (dct_ready),
        .test_has_ended  (test_has_ended),
        .atom_drop_count (atom_drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic send(input logic [1:0] a);
        int n = 0;
        atom_valid = 1'b1;
        atom       = a;
        while (!atom_ready && n < 50) begin
            step();
            n++;
        end
        chk("send_timeout", 32'(n < 50), 32'd1);
        step();
        atom_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    initial begin
        int n;
        reset_n     = 1'b0;
        atom_valid  = 1'b0;
        atom        = 2'd0;
        flush       = 1'b0;
        test_ending = 1'b0;
        dct_ready   = 1'b1;
        do_reset();

        chk("rst_valid", 32'(dct_valid), 32'd0);
        chk("rst_count", 32'(dct_count), 32'd0);
        chk("rst_buffer", 32'(dct_buffer), 32'd0);
        chk("rst_ended", 32'(test_has_ended), 32'd0);
        chk("rst_drop", 32'(atom_drop_count), 32'd0);
        chk("rst_ready", 32'(atom_ready), 32'd1);

        // Full frame of 0,1,2,3,... : atom k at [2k+1:2k] gives 24E4E4E4.
        for (int i = 0; i < 15; i++) send(2'(i % 4));
        chk("full_ready_low", 32'(atom_ready), 32'd0);
        chk("full_not_yet", 32'(dct_valid), 32'd0);
        step();
        chk("full_valid", 32'(dct_valid), 32'd1);
        chk("full_ready_back", 32'(atom_ready), 32'd1);
        chk("full_count", 32'(dct_count), 32'd15);
        chk("full_buffer", 32'(dct_buffer), 32'h24E4E4E4);
        step();
        chk("full_taken", 32'(dct_valid), 32'd0);

        // Explicit flush of 3 atoms.
        send(2'd3);
        send(2'd2);
        send(2'd1);
        pulse_flush();
        chk("flush_pending", 32'(dct_valid), 32'd0);
        step();
        chk("flush_valid", 32'(dct_valid), 32'd1);
        chk("flush_count", 32'(dct_count), 32'd3);
        chk("flush_buffer", 32'(dct_buffer), 32'h1B);
        step();
        chk("flush_taken", 32'(dct_valid), 32'd0);

        // Flush transfer coinciding with an acceptance.
        send(2'd1);
        send(2'd2);
        pulse_flush();
        atom_valid = 1'b1;
        atom       = 2'd3;
        chk("coin_ready", 32'(atom_ready), 32'd1);
        step();
        atom_valid = 1'b0;
        chk("coin_count", 32'(dct_count), 32'd2);
        chk("coin_buffer", 32'(dct_buffer), 32'h9);
        pulse_flush();
        step();
        chk("coin_next_count", 32'(dct_count), 32'd1);
        chk("coin_next_buffer", 32'(dct_buffer), 32'h3);
        step();

        // Flush with empty accumulator emits nothing.
        pulse_flush();
        step();
        step();
        chk("empty_flush", 32'(dct_valid), 32'd0);

        // Idle timeout: 4 idle edges, then one more to the frame.
        send(2'd0);
        send(2'd1);
        send(2'd2);
        n = 0;
        while (!dct_valid && n < 20) begin
            step();
            n++;
        end
        chk("timeout_latency", 32'(n), 32'd5);
        chk("timeout_count", 32'(dct_count), 32'd3);
        chk("timeout_buffer", 32'(dct_buffer), 32'h24);
        step();

        // Back-pressure with a continuous stream.
        do_reset();
        dct_ready  = 1'b0;
        atom_valid = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            atom = (i < 16) ? 2'd1 : 2'd2;
            step();
        end
        chk("bp_valid", 32'(dct_valid), 32'd1);
        chk("bp_count", 32'(dct_count), 32'd15);
        chk("bp_buffer", 32'(dct_buffer), 32'h15555555);
        chk("bp_ready", 32'(atom_ready), 32'd0);
`ifdef SCOPE_DCT_DROP_COUNT_EN
        chk("bp_drop", 32'(atom_drop_count), 32'd10);
`else
        chk("bp_drop", 32'(atom_drop_count), 32'd0);
`endif
        atom_valid = 1'b0;
        dct_ready  = 1'b1;
        step();
        chk("bp_second_valid", 32'(dct_valid), 32'd1);
        chk("bp_second_buffer", 32'(dct_buffer), 32'h2AAAAAAA);
        step();
        chk("bp_drained", 32'(dct_valid), 32'd0);

        // End of trace with 5 atoms held.
        do_reset();
        for (int i = 0; i < 5; i++) send(2'd3);
        test_ending = 1'b1;
        step();
        chk("drain_ready", 32'(atom_ready), 32'd0);
        n = 0;
        while (!dct_valid && n < 10) begin
            step();
            n++;
        end
        chk("drain_frame_seen", 32'(dct_valid), 32'd1);
        chk("drain_count", 32'(dct_count), 32'd5);
        chk("drain_buffer", 32'(dct_buffer), 32'h3FF);
        n = 0;
        while (!test_has_ended && n < 10) begin
            step();
            n++;
        end
        chk("ended", 32'(test_has_ended), 32'd1);
        atom_valid = 1'b1;
        step();
        chk("ended_ready", 32'(atom_ready), 32'd0);
        chk("ended_hold", 32'(test_has_ended), 32'd1);
        atom_valid  = 1'b0;
        test_ending = 1'b0;

        // Reset mid-frame discards held atoms.
        do_reset();
        for (int i = 0; i < 7; i++) send(2'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("mid_rst_valid", 32'(dct_valid), 32'd0);
        chk("mid_rst_count", 32'(dct_count), 32'd0);
        chk("mid_rst_buffer", 32'(dct_buffer), 32'd0);
        chk("mid_rst_ended", 32'(test_has_ended), 32'd0);
        chk("mid_rst_ready", 32'(atom_ready), 32'd1);
        send(2'd2);
        pulse_flush();
        step();
        chk("mid_rst_next_count", 32'(dct_count), 32'd1);
        chk("mid_rst_next_buffer", 32'(dct_buffer), 32'h2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
